// File: rtl/param_fifo_pkg.sv
// Shared helpers for the parametrised FIFO: constant log2 plus the
// pointer-width / count-width relationship (PW = clog2(DEPTH), CW = PW + 1).
package param_fifo_pkg;

    // Ceiling log2 usable in parameter/localparam expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Pointer width: wraps naturally modulo a power-of-two DEPTH.
    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    // Count width: one extra bit so the value DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered
// read port. The read register resets to INIT_W; the array itself is never
// cleared, so a reset only discards entries logically.
module param_fifo_mem
    import param_fifo_pkg::*;
#(
    parameter int               WIDTH  = 4,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] INIT_W = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [ptr_w(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    input  logic [ptr_w(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]        o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register: old contents are returned on a same-address write,
    // which is what a full FIFO doing read+write in one cycle needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= INIT_W;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/param_init_fifo.sv
// Synchronous single-clock FIFO. Holds pointers, occupancy count, sticky
// error flags and the read/write accept logic; storage lives in
// param_fifo_mem. Status outputs are decoded from the registered count.
module param_init_fifo
    import param_fifo_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 2,
    parameter     INIT        = 0,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    // INIT may be any width; fit it to WIDTH by truncation / zero-extension.
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_empty;
    logic          w_full;
    logic          w_rd_acc;
    logic          w_wr_acc;

    // Accept rules. A read frees a slot in the same cycle, so a full FIFO
    // still accepts a write alongside an accepted read. There is no
    // fall-through: a read on an empty FIFO is rejected even if a write
    // arrives in the same cycle. Nothing is accepted while rst is high.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_rd_acc = rd_en & ~w_empty & ~rst;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc) & ~rst;

    param_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .INIT_W (INIT_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rd_data)
    );

    // Pointers wrap modulo DEPTH; count moves only when exactly one side is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // One-cycle valid pulse plus sticky error flags; a set beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= (wr_en & ~w_wr_acc) | (r_overflow & ~clr_err);
            r_underflow <= (rd_en & ~w_rd_acc) | (r_underflow & ~clr_err);
        end
    end

    assign rd_valid    = r_rd_valid;
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= CW'(AFULL_LEVEL));
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: doc/param_init_fifo.md
# param_init_fifo

Synchronous single-clock FIFO, the parametrised successor to the WIDTH/DEPTH/INIT constant-output block used across the defparam and parameter-override test suites. WIDTH, DEPTH and INIT now drive real storage: DEPTH sets capacity, and INIT sets the reset and idle value of the registered read port. It adds occupancy reporting, an almost-full threshold and sticky error flags. It is the standard buffer in multi-instance parameter and defparam regression benches.

## Interface
- WIDTH, 4: data width in bits, ≥1.
- DEPTH, 2: capacity in entries; power of two, ≥2.
- INIT, 0: value driven on rd_data out of reset; truncated or zero-extended to WIDTH.
- AFULL_LEVEL, DEPTH-1: count at or above which almost_full asserts; legal range 1..DEPTH.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- clr_err  in  1  clears the sticky error flags.
- rd_data  out  WIDTH  registered read data; reset value INIT.
- rd_valid  out  1  one-cycle pulse marking new rd_data; reset 0.
- full  out  1  count == DEPTH; reset 0.
- empty  out  1  count == 0; reset 1.
- almost_full  out  1  count ≥ AFULL_LEVEL; reset 0.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH; reset 0.
- overflow  out  1  sticky flag for a rejected write; reset 0.
- underflow  out  1  sticky flag for a rejected read; reset 0.

## Operation
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. count is tracked separately and never wraps.
- Read accept: rd_acc = rd_en & ~empty.
- Write accept: wr_acc = wr_en & (~full | rd_acc). A write to a full FIFO succeeds when a read is accepted in the same cycle.
- Write and read on an empty FIFO in the same cycle: the write is accepted and the read is rejected. There is no fall-through, and underflow sets.
- count update: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- On rd_acc: rd_data ← mem[rd_ptr] and rd_valid ← 1. Otherwise rd_valid ← 0 and rd_data holds its last value.
- overflow sets on wr_en & ~wr_acc; underflow sets on rd_en & ~rd_acc.
- clr_err clears both error flags. If a set condition and clr_err occur in the same cycle, the flag is set.
- Reset mid-operation: pointers, count and flags clear, and rd_data ← INIT. Stored entries are discarded logically; mem contents are not cleared.
- While rst is high, wr_en and rd_en are ignored and no error flags set.

## Timing
- Read latency 1: rd_data and rd_valid are valid in the cycle after the accepted rd_en.
- Write-to-read latency 1: a word written in cycle N can be accepted by a read in cycle N+1 and appears on rd_data in N+2.
- full, empty, almost_full and count are registered (or decoded from registered count). They reflect accepted operations from the previous edge.
- First edge with rst=1 forces every output to its reset value. The first accepted operation is on the edge after rst deasserts.
- Sustained simultaneous read and write at any occupancy from 1 to DEPTH runs one word per cycle with count constant.

## Structure
- Shared package param_fifo_pkg: clog2 constant function, plus localparam conventions for pointer width PW and count width CW = PW+1.
- Sub-module param_fifo_mem: DEPTH×WIDTH array, one synchronous write port, one synchronous read port with enable and INIT reset on the output register. The top level holds pointers, count, flags and accept logic.

## Test plan
- Reset, then a defparam instance with WIDTH=8, INIT=8'hAB and another with INIT=8'hCD -> rd_data equals AB and CD respectively, empty=1, count=0.
- DEPTH=4: write 11,22,33,44, then read 4 times -> full=1 after 4th write; rd_data sequence 11,22,33,44 each with a one-cycle rd_valid; empty=1 at end.
- Full FIFO, then wr_en alone -> overflow=1 and count stays 4. Next cycle, wr_en+rd_en -> both accepted, count=4, and overflow stays set until clr_err.
- Empty FIFO, then wr_en+rd_en with data 5A -> count=1, rd_valid=0, underflow=1. Next-cycle read -> rd_data=5A.
- AFULL_LEVEL=3, DEPTH=4: writes 1..3 -> almost_full rises on the 3rd write and falls after one read.
- Fill to 3, assert rst for one cycle mid-stream -> count=0, empty=1, rd_data=INIT, flags 0. Then write and read 7E -> rd_data=7E, showing pointers restarted cleanly.
